// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Round-robin arbiter for the single write port of a register bank. Four
// requesters present valid/ready write requests. One request is granted per
// cycle, and the winning write is registered onto the bank's write port. A
// requester can lock the port for a burst. A burst is released when the owner
// drops its lock request, or by force after LOCK_MAX cycles in LOCKED.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous active-low reset
//   req_valid  per-requester write request valid
//   req_lock   per-requester request to keep the port after this transfer
//   req_addr   requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   requester i data at [i*REG_WIDTH +: REG_WIDTH]
//   req_ready  one-hot grant (combinational)
//   wr_en      registered write enable to the bank
//   wr_addr    registered write address
//   wr_data    registered write data
//   wr_src     registered index of the requester behind this write
//   locked     high while the port is locked by an owner
module reg_write_arbiter #(
  parameter int REG_WIDTH  = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int LOCK_MAX   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req_valid,
  input  logic [3:0]              req_lock,
  input  logic [4*ADDR_WIDTH-1:0] req_addr,
  input  logic [4*REG_WIDTH-1:0]  req_data,
  output logic [3:0]              req_ready,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [REG_WIDTH-1:0]    wr_data,
  output logic [1:0]              wr_src,
  output logic                    locked
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  state_e                state_q, state_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [1:0]            owner_q, owner_d;
  logic [7:0]            lock_cnt_q, lock_cnt_d;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [REG_WIDTH-1:0]  wr_data_q;
  logic [1:0]            wr_src_q;

  logic                  win_found;
  logic [1:0]            win_idx;
  logic [1:0]            scan_idx;
  logic [3:0]            grant;
  logic [1:0]            gnt_idx;
  logic                  xfer;
  logic                  xfer_lock;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [REG_WIDTH-1:0]  sel_data;

  // Round-robin scan: first valid requester starting at rr_ptr, wrapping mod 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    scan_idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr_q + 2'(k);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end else begin
        win_found = win_found;
      end
    end
  end

  // Grant selection. While LOCKED, only the owner can be granted.
  always_comb begin
    grant   = 4'b0000;
    gnt_idx = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant[win_idx] = 1'b1;
          gnt_idx        = win_idx;
        end else begin
          grant = 4'b0000;
        end
      end
      ST_LOCKED: begin
        grant[owner_q] = req_valid[owner_q];
        gnt_idx        = owner_q;
      end
      default: begin
        grant   = 4'b0000;
        gnt_idx = 2'd0;
      end
    endcase
  end

  // Ready is forced low while reset is held, independent of the FSM state.
  assign req_ready = rst ? grant : 4'b0000;
  assign xfer      = |(req_valid & req_ready);
  assign xfer_lock = req_lock[gnt_idx];
  assign sel_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data  = req_data[gnt_idx*REG_WIDTH +: REG_WIDTH];

  // Next-state logic for the FSM, round-robin pointer, owner and lock counter.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (xfer_lock) begin
            state_d    = ST_LOCKED;
            owner_d    = gnt_idx;
            lock_cnt_d = 8'd1;
          end else begin
            rr_ptr_d = gnt_idx + 2'd1;
          end
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      ST_LOCKED: begin
        // A forced release takes priority over an owner transfer that still
        // requests the lock. The transfer in that cycle still goes through.
        if ((lock_cnt_q == LOCK_MAX_C) || (xfer && !xfer_lock)) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = owner_q + 2'd1;
          lock_cnt_d = 8'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = 8'd0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd0;
      owner_q    <= 2'd0;
      lock_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Write stage. Address, data and source hold their values between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= 2'd0;
    end else if (xfer) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= sel_addr;
      wr_data_q <= sel_data;
      wr_src_q  <= gnt_idx;
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;
  assign locked  = (state_q == ST_LOCKED);

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter that shares the single write port of the register bank (a set of REG_WIDTH-bit flip-flop registers) among four requesters. Each requester presents a valid/ready write request (address plus data). The arbiter grants one request per cycle and registers the winning write onto the bank's write port. A requester may lock the port for a burst, bounded by a timeout.

## Interface
Parameters:
- REG_WIDTH, 16, data width of one register
- ADDR_WIDTH, 3, register address width (8 registers)
- LOCK_MAX, 8, maximum consecutive cycles a lock may be held (2..255)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  4  per-requester write request valid
- req_lock  input  4  per-requester request to keep the port after this transfer
- req_addr  input  4*ADDR_WIDTH  requester i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  input  4*REG_WIDTH  requester i data at bits [i*REG_WIDTH +: REG_WIDTH]
- req_ready  output  4  one-hot grant; at most one bit set; combinational
- wr_en  output  1  registered write enable to the register bank
- wr_addr  output  ADDR_WIDTH  registered write address
- wr_data  output  REG_WIDTH  registered write data
- wr_src  output  2  registered index of the requester that produced this write
- locked  output  1  high while in LOCKED state

## Operation
- Transfer on requester i happens when req_valid[i] & req_ready[i] in the same cycle.
- Requesters hold valid, addr, data and lock stable until transfer. The arbiter never withdraws ready from a still-valid winner within a cycle.
- State: rr_ptr (2 bits, highest-priority index), FSM {IDLE, LOCKED}, owner (2 bits), lock_cnt (8 bits).
- IDLE:
  - Winner is the first valid requester scanning rr_ptr, rr_ptr+1, ... mod 4.
  - req_ready is one-hot on the winner, or all zero if no requester is valid.
  - On transfer with req_lock[winner]=0: rr_ptr <= winner+1 mod 4.
  - On transfer with req_lock[winner]=1: go to LOCKED, owner <= winner, lock_cnt <= 1, rr_ptr unchanged.
- LOCKED:
  - req_ready[owner] = req_valid[owner]; all other ready bits are 0.
  - lock_cnt increments every cycle spent in LOCKED, whether or not a transfer occurs.
  - Exit to IDLE with rr_ptr <= owner+1 on either of these events:
    - an owner transfer with req_lock[owner]=0 (that transfer is still performed);
    - lock_cnt == LOCK_MAX at a clock edge (forced release; any transfer in that cycle is still performed).
- Write stage:
  - On any transfer: wr_en <= 1, wr_addr/wr_data <= the winner's fields, wr_src <= winner.
  - Otherwise wr_en <= 0; wr_addr, wr_data and wr_src hold their previous values.
- Widths: rr_ptr and owner wrap mod 4. lock_cnt never exceeds LOCK_MAX.

## Timing
- Reset (rst=0, asynchronous): wr_en=0, wr_addr=0, wr_data=0, wr_src=0, locked=0, FSM=IDLE, rr_ptr=0, owner=0, lock_cnt=0.
- req_ready during reset is 0.
- A write in flight at reset assertion is dropped.
- Grant latency: req_ready is in the same cycle as req_valid, combinational from valid, FSM and rr_ptr.
- Write latency: wr_en is asserted on the cycle after the transfer (1 cycle).
- Throughput: one write per cycle.
- locked rises the cycle after a locking transfer. It falls the cycle after the release edge.
- Simultaneous events:
  - Forced release and owner transfer with lock=1 in the same cycle: the transfer completes and release wins.
  - All four requesters valid: strict rotation 0,1,2,3,0,... starting from reset.

## Test plan
- Single requester: reset, req_valid=4'b0100, addr=5, data=16'hBEEF. Expect req_ready=4'b0100 the same cycle; wr_en=1, wr_addr=5, wr_data=16'hBEEF, wr_src=2 the next cycle; rr_ptr becomes 3.
- Rotation fairness: all four valid continuously for 8 cycles, lock=0. Expect wr_src sequence 0,1,2,3,0,1,2,3 with wr_en high every cycle from cycle 1.
- Lock burst: requester 1 valid with lock=1 for 3 transfers, then lock=0, while requesters 0, 2 and 3 are valid. Expect 4 consecutive writes with wr_src=1, locked high during the burst, then the next grant goes to requester 2.
- Lock timeout: LOCK_MAX=8, requester 3 holds lock=1 and valid indefinitely, others valid. Expect locked to drop after 8 LOCKED cycles and the next grant to go to requester 0; requester 3 is not re-granted until 1 and 2 have each been served.
- Idle/bubble: no requests for 5 cycles. Expect req_ready=0 and wr_en=0, with wr_addr and wr_data holding their last values.
- Reset mid-burst: assert rst low while LOCKED with wr_en=1. Expect all outputs zero immediately without waiting for a clock edge; after release the first grant goes to the lowest-index valid requester (rr_ptr=0).
